// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin read arbiter between NUM_REQ request FIFOs and
// one shared-memory bank port. A grant issues a single read-enable pulse to
// the winning FIFO, captures the word it returns one cycle later, and offers
// that word, tagged with its source index, on a valid/ready port.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transaction; search fifo_req from rr_ptr for a winner
// RD    | read enable high to the granted FIFO for exactly this cycle
// CAP   | FIFO read data valid; capture it into the output register
// SEND  | word held on the memory port until the bank accepts it
module fifo_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 32,
    parameter int SRC_W      = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_fifo_req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] i_fifo_rd_data,
    output logic [NUM_REQ-1:0]            o_fifo_rd_en,
    output logic                          o_mem_valid,
    input  logic                          i_mem_ready,
    output logic [FIFO_WIDTH-1:0]         o_mem_data,
    output logic [SRC_W-1:0]              o_mem_src,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic                          o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_CAP  = 2'd2,
        ST_SEND = 2'd3
    } state_t;

    localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_REQ - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [SRC_W-1:0]        r_rr_ptr;
    logic [NUM_REQ-1:0]      r_fifo_rd_en;
    logic [NUM_REQ-1:0]      r_grant;
    logic                    r_mem_valid;
    logic [FIFO_WIDTH-1:0]   r_mem_data;
    logic [SRC_W-1:0]        r_mem_src;

    logic [SRC_W-1:0]        w_rr_ptr_nxt;
    logic [NUM_REQ-1:0]      w_fifo_rd_en_nxt;
    logic [NUM_REQ-1:0]      w_grant_nxt;
    logic                    w_mem_valid_nxt;
    logic [FIFO_WIDTH-1:0]   w_mem_data_nxt;
    logic [SRC_W-1:0]        w_mem_src_nxt;

    logic                    w_found;
    logic [SRC_W-1:0]        w_winner;
    logic [SRC_W-1:0]        w_scan_idx;
    logic [NUM_REQ-1:0]      w_winner_oh;
    logic [SRC_W-1:0]        w_src_inc;
    logic [FIFO_WIDTH-1:0]   w_cap_data;
    logic                    w_handshake;

    assign w_handshake = r_mem_valid && i_mem_ready;

    // Pointer after the current source; wraps explicitly so non-power-of-2
    // NUM_REQ never lands on a FIFO that does not exist.
    assign w_src_inc = (r_mem_src == LAST_IDX) ? '0 : r_mem_src + 1'b1;

    // Round-robin search: first requesting FIFO at or above rr_ptr, wrapping.
    always_comb begin
        w_found    = 1'b0;
        w_winner   = '0;
        w_scan_idx = r_rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && i_fifo_req[w_scan_idx]) begin
                w_found  = 1'b1;
                w_winner = w_scan_idx;
            end
            w_scan_idx = (w_scan_idx == LAST_IDX) ? '0 : w_scan_idx + 1'b1;
        end
    end

    assign w_winner_oh = NUM_REQ'(1) << w_winner;

    // Select the granted FIFO's read-data slice for capture.
    always_comb begin
        w_cap_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_mem_src == SRC_W'(i)) begin
                w_cap_data = i_fifo_rd_data[i*FIFO_WIDTH +: FIFO_WIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: fixed IDLE->RD->CAP->SEND walk, SEND exits on handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_found) w_state_nxt = ST_RD;
            ST_RD:   w_state_nxt = ST_CAP;
            ST_CAP:  w_state_nxt = ST_SEND;
            ST_SEND: if (w_handshake) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, plus busy.
    always_comb begin
        w_rr_ptr_nxt     = r_rr_ptr;
        w_fifo_rd_en_nxt = '0;
        w_grant_nxt      = r_grant;
        w_mem_valid_nxt  = r_mem_valid;
        w_mem_data_nxt   = r_mem_data;
        w_mem_src_nxt    = r_mem_src;
        o_busy           = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_grant_nxt      = w_winner_oh;
                    w_fifo_rd_en_nxt = w_winner_oh;
                    w_mem_src_nxt    = w_winner;
                end
            end
            ST_RD: begin
                w_rr_ptr_nxt = w_src_inc;
            end
            ST_CAP: begin
                w_mem_data_nxt  = w_cap_data;
                w_mem_valid_nxt = 1'b1;
            end
            ST_SEND: begin
                // mem_ready only matters here; elsewhere it is ignored.
                if (w_handshake) begin
                    w_mem_valid_nxt = 1'b0;
                    w_grant_nxt     = '0;
                end
            end
            default: begin
                w_grant_nxt     = '0;
                w_mem_valid_nxt = 1'b0;
            end
        endcase
    end

    // Datapath registers; reset drops any in-flight word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr     <= '0;
            r_fifo_rd_en <= '0;
            r_grant      <= '0;
            r_mem_valid  <= 1'b0;
            r_mem_data   <= '0;
            r_mem_src    <= '0;
        end else begin
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_fifo_rd_en <= w_fifo_rd_en_nxt;
            r_grant      <= w_grant_nxt;
            r_mem_valid  <= w_mem_valid_nxt;
            r_mem_data   <= w_mem_data_nxt;
            r_mem_src    <= w_mem_src_nxt;
        end
    end

    assign o_fifo_rd_en = r_fifo_rd_en;
    assign o_grant      = r_grant;
    assign o_mem_valid  = r_mem_valid;
    assign o_mem_data   = r_mem_data;
    assign o_mem_src    = r_mem_src;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: four modelled FIFOs feed the arbiter; a
// transaction-level reference predicts every output on every cycle.
module tb_fifo_rr_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic [N-1:0]   i_fifo_req;
    logic [N*W-1:0] i_fifo_rd_data;
    logic [N-1:0]   o_fifo_rd_en;
    logic           o_mem_valid;
    logic           i_mem_ready;
    logic [W-1:0]   o_mem_data;
    logic [1:0]     o_mem_src;
    logic [N-1:0]   o_grant;
    logic           o_busy;

    fifo_rr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .SRC_W(2)) u_dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_fifo_req     (i_fifo_req),
        .i_fifo_rd_data (i_fifo_rd_data),
        .o_fifo_rd_en   (o_fifo_rd_en),
        .o_mem_valid    (o_mem_valid),
        .i_mem_ready    (i_mem_ready),
        .o_mem_data     (o_mem_data),
        .o_mem_src      (o_mem_src),
        .o_grant        (o_grant),
        .o_busy         (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // FIFO contents
    logic [W-1:0] fmem [N][64];
    int fhead [N];
    int ftail [N];
    logic [N-1:0] en_pending;

    // observed traffic
    int           xlog_src [$];
    logic [W-1:0] xlog_data [$];
    int           en_cnt [N];
    int           en_cyc2 [$];

    // reference model: one transaction at a time
    bit           m_active;
    int           m_t0;       // cycle in which the read enable is high
    int           m_ptr;
    int           m_src;
    logic [W-1:0] m_word;
    logic [W-1:0] m_data;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void push(input int i, input logic [W-1:0] d);
        fmem[i][ftail[i] % 64] = d;
        ftail[i]++;
    endfunction

    function automatic int fcnt(input int i);
        return ftail[i] - fhead[i];
    endfunction

    task automatic fifo_env();
        for (int i = 0; i < N; i++) begin
            if (en_pending[i] === 1'b1) begin
                check_val("no_underflow", 64'(fcnt(i) > 0), 64'd1);
                if (fcnt(i) > 0) begin
                    i_fifo_rd_data[i*W +: W] = fmem[i][fhead[i] % 64];
                    fhead[i]++;
                end else begin
                    i_fifo_rd_data[i*W +: W] = $urandom;
                end
            end else begin
                i_fifo_rd_data[i*W +: W] = $urandom;
            end
            i_fifo_req[i] = (fcnt(i) != 0);
        end
    endtask

    task automatic model_step(input logic rst_v, input logic rdy_v);
        bit found;
        int w;
        if (rst_v) begin
            m_active = 0;
            m_ptr    = 0;
            m_src    = 0;
            m_data   = '0;
        end else if (m_active) begin
            if (cyc == m_t0 + 1) m_data = m_word;
            else if (cyc >= m_t0 + 2 && rdy_v) m_active = 0;
        end else begin
            found = 0;
            w = 0;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (!found && i_fifo_req[idx] === 1'b1) begin
                    found = 1;
                    w = idx;
                end
            end
            if (found) begin
                m_active = 1;
                m_t0     = cyc + 1;
                m_src    = w;
                m_ptr    = (w + 1) % N;
                m_word   = (fcnt(w) > 0) ? fmem[w][fhead[w] % 64] : '0;
            end
        end
    endtask

    task automatic compare();
        logic [N-1:0] exp_oh;
        exp_oh = m_active ? (N'(1) << m_src) : '0;
        check_val("rd_en", o_fifo_rd_en, (m_active && cyc == m_t0) ? exp_oh : '0);
        check_val("grant", o_grant, exp_oh);
        check_val("mem_valid", o_mem_valid, 64'(m_active && cyc >= m_t0 + 2));
        check_val("busy", o_busy, 64'(m_active));
        check_val("mem_src", o_mem_src, 64'(m_src));
        check_val("mem_data", o_mem_data, m_data);
    endtask

    // one clock: drive at negedge, FIFOs update just after posedge, check at negedge
    task automatic tick(input logic rst_v, input logic rdy_v);
        i_rst       = rst_v;
        i_mem_ready = rdy_v;
        if (!rst_v && rdy_v && o_mem_valid === 1'b1) begin
            xlog_src.push_back(int'(o_mem_src));
            xlog_data.push_back(o_mem_data);
        end
        en_pending = o_fifo_rd_en;
        for (int i = 0; i < N; i++) begin
            if (o_fifo_rd_en[i] === 1'b1) begin
                en_cnt[i]++;
                if (i == 2) en_cyc2.push_back(cyc);
            end
        end
        model_step(rst_v, rdy_v);
        @(posedge i_clk);
        #1;
        fifo_env();
        @(negedge i_clk);
        cyc++;
        compare();
    endtask

    task automatic run(input int n, input logic rdy);
        repeat (n) tick(1'b0, rdy);
    endtask

    task automatic wait_xfers(input int target, input int budget);
        int n;
        n = 0;
        while (xlog_src.size() < target && n < budget) begin
            tick(1'b0, 1'b1);
            n++;
        end
        check_val("xfer_count", xlog_src.size(), target);
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (o_mem_valid !== 1'b1 && n < budget) begin
            tick(1'b0, 1'b0);
            n++;
        end
        check_val("valid_seen", o_mem_valid, 1);
    endtask

    task automatic clear_logs();
        xlog_src.delete();
        xlog_data.delete();
        en_cyc2.delete();
        for (int i = 0; i < N; i++) en_cnt[i] = 0;
    endtask

    initial begin
        i_rst          = 1'b1;
        i_mem_ready    = 1'b0;
        i_fifo_req     = '0;
        i_fifo_rd_data = '0;
        en_pending     = '0;
        m_active = 0; m_t0 = 0; m_ptr = 0; m_src = 0; m_word = '0; m_data = '0;
        for (int i = 0; i < N; i++) begin
            fhead[i] = 0; ftail[i] = 0; en_cnt[i] = 0;
        end

        // reset held with all FIFOs requesting; first grant must be FIFO 0
        for (int i = 0; i < N; i++) push(i, 32'h100 + i);
        @(negedge i_clk);
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b1, 1'b0);
        check_val("rst_no_rd_en", en_cnt[0] + en_cnt[1] + en_cnt[2] + en_cnt[3], 0);
        clear_logs();
        wait_xfers(4, 40);
        for (int k = 0; k < 4 && k < xlog_src.size(); k++) begin
            check_val("rst_first_rr_src", xlog_src[k], k);
            check_val("rst_first_rr_data", xlog_data[k], 32'h100 + k);
        end
        run(3, 1'b1);

        // single source, three back-to-back words
        clear_logs();
        push(2, 32'hA0); push(2, 32'hA1); push(2, 32'hA2);
        wait_xfers(3, 60);
        run(4, 1'b1);
        for (int k = 0; k < 3 && k < xlog_src.size(); k++) begin
            check_val("single_src", xlog_src[k], 2);
            check_val("single_data", xlog_data[k], 32'hA0 + k);
        end
        check_val("single_pulses", en_cnt[2], 3);
        for (int k = 1; k < en_cyc2.size(); k++)
            check_val("single_spacing", en_cyc2[k] - en_cyc2[k-1], 4);
        check_val("single_idle", o_busy, 0);

        // pointer sits at 3; only FIFO 1 requests -> search wraps to 1
        clear_logs();
        push(1, 32'h11);
        wait_xfers(1, 30);
        if (xlog_src.size() > 0) check_val("wrap_src", xlog_src[0], 1);
        run(2, 1'b1);

        // round robin from a fresh pointer, two words per FIFO
        tick(1'b1, 1'b0);
        clear_logs();
        for (int i = 0; i < N; i++) begin
            push(i, 32'hB000 + i);
            push(i, 32'hB010 + i);
        end
        wait_xfers(8, 100);
        for (int k = 0; k < 8 && k < xlog_src.size(); k++)
            check_val("rr_src", xlog_src[k], k % 4);
        run(3, 1'b1);

        // backpressure: word stays put while the bank is not ready
        clear_logs();
        push(1, 32'h55);
        wait_valid(20);
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, 1'b0);
            check_val("bp_valid", o_mem_valid, 1);
            check_val("bp_data", o_mem_data, 32'h55);
        end
        check_val("bp_no_xfer", xlog_src.size(), 0);
        tick(1'b0, 1'b1);
        check_val("bp_xfer", xlog_src.size(), 1);
        check_val("bp_valid_drop", o_mem_valid, 0);
        check_val("bp_pulses", en_cnt[1], 1);
        run(2, 1'b1);

        // reset in SEND drops the word and restarts the pointer at 0
        clear_logs();
        push(1, 32'h66);
        wait_valid(20);
        tick(1'b1, 1'b0);
        check_val("midrst_valid", o_mem_valid, 0);
        check_val("midrst_busy", o_busy, 0);
        check_val("midrst_no_xfer", xlog_src.size(), 0);
        push(0, 32'h70);
        push(2, 32'h72);
        wait_xfers(2, 40);
        if (xlog_src.size() > 0) check_val("midrst_ptr0", xlog_src[0], 0);
        run(3, 1'b1);

        // randomized traffic, backpressure and occasional reset
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 7) == 0 && fcnt(i) < 8) push(i, $urandom);
            tick(logic'($urandom_range(0, 199) == 0), logic'($urandom_range(0, 2) != 0));
        end
        run(60, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
